// File: rtl/led_flicker_gen.sv
// LED flicker generator.
//
// Divides clk_i down to a tick time base and toggles the LED every act_hp
// ticks, where act_hp is a shadow copy of half_period_i that is reloaded only
// at toggle boundaries. With a zero half-period the block idles, LED off.
//
// Ports:
//   clk_i                 - clock, all logic on the rising edge
//   srst_n_i              - synchronous active-low reset
//   half_period_i         - requested half-period in ticks (0 = off)
//   led_o                 - registered LED drive (polarity set by LED_ACTIVE_LOW)
//   toggle_stb_o          - one-cycle pulse in the cycle led_o shows its new level
//   active_half_period_o  - half-period currently in use
module led_flicker_gen #(
    parameter int unsigned CLK_FREQ_HZ    = 25_000_000,
    parameter int unsigned TICK_HZ        = 1000,
    parameter int unsigned REG_SIZE       = 32,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic                clk_i,
    input  logic                srst_n_i,
    input  logic [REG_SIZE-1:0] half_period_i,
    output logic                led_o,
    output logic                toggle_stb_o,
    output logic [REG_SIZE-1:0] active_half_period_o
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]       PrescMax = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]       PrescOne = PW'(1);
    localparam logic [REG_SIZE-1:0] One      = REG_SIZE'(1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("led_flicker_gen: CLK_FREQ_HZ / TICK_HZ must be at least 2");
    end

    // IDLE/RUN is fully determined by whether a half-period is loaded.
    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e              state;
    logic                tick;
    logic [PW-1:0]       presc_q, presc_d;
    logic [REG_SIZE-1:0] cnt_q, cnt_d;
    logic [REG_SIZE-1:0] act_hp_q, act_hp_d;
    logic                lvl_q, lvl_d;
    logic                stb_q, stb_d;
    logic                led_q;

    always_comb begin
        state = (act_hp_q == '0) ? StIdle : StRun;
    end

    always_comb begin
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        act_hp_d = act_hp_q;
        lvl_d    = lvl_q;
        stb_d    = 1'b0;
        tick     = 1'b0;

        unique case (state)
            StIdle: begin
                presc_d = '0;
                cnt_d   = '0;
                lvl_d   = 1'b0;
                if (half_period_i != '0) begin
                    act_hp_d = half_period_i;
                end
            end
            StRun: begin
                tick    = (presc_q == PrescMax);
                presc_d = tick ? '0 : presc_q + PrescOne;
                if (tick) begin
                    // Last tick of the half-period: the only point where a new
                    // half_period_i is accepted, so a running period always
                    // completes with its original length.
                    if (cnt_q == act_hp_q - One) begin
                        cnt_d    = '0;
                        act_hp_d = half_period_i;
                        if (half_period_i == '0) begin
                            lvl_d = 1'b0;
                        end else begin
                            lvl_d = ~lvl_q;
                            stb_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + One;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            act_hp_q <= '0;
            lvl_q    <= 1'b0;
            stb_q    <= 1'b0;
            led_q    <= LED_ACTIVE_LOW;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            act_hp_q <= act_hp_d;
            lvl_q    <= lvl_d;
            stb_q    <= stb_d;
            led_q    <= lvl_d ^ LED_ACTIVE_LOW;
        end
    end

    assign led_o                = led_q;
    assign toggle_stb_o         = stb_q;
    assign active_half_period_o = act_hp_q;

endmodule

// File: tb/tb_led_flicker_gen.sv
// Self-checking bench for led_flicker_gen (TICK_DIV = 10, REG_SIZE = 32).
// Two instances share the stimulus: one active-high, one active-low LED.
module tb_led_flicker_gen;

    localparam int TD = 10;

    logic        clk;
    logic        srst_n;
    logic [31:0] hp;
    logic        led_a, stb_a, led_b, stb_b;
    logic [31:0] act_a, act_b;

    led_flicker_gen #(
        .CLK_FREQ_HZ   (10_000),
        .TICK_HZ       (1000),
        .REG_SIZE      (32),
        .LED_ACTIVE_LOW(1'b0)
    ) u_dut_a (
        .clk_i               (clk),
        .srst_n_i            (srst_n),
        .half_period_i       (hp),
        .led_o               (led_a),
        .toggle_stb_o        (stb_a),
        .active_half_period_o(act_a)
    );

    led_flicker_gen #(
        .CLK_FREQ_HZ   (10_000),
        .TICK_HZ       (1000),
        .REG_SIZE      (32),
        .LED_ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .clk_i               (clk),
        .srst_n_i            (srst_n),
        .half_period_i       (hp),
        .led_o               (led_b),
        .toggle_stb_o        (stb_b),
        .active_half_period_o(act_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc  = 0;

    // Reference model: clocks elapsed since the last RUN entry / boundary.
    logic [31:0] m_act = 32'd0;
    longint      m_el  = 0;
    logic        m_led = 1'b0;
    logic        m_stb = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endfunction

    task automatic model_step();
        if (!srst_n) begin
            m_act = 32'd0;
            m_el  = 0;
            m_led = 1'b0;
            m_stb = 1'b0;
        end else if (m_act == 32'd0) begin
            m_stb = 1'b0;
            m_led = 1'b0;
            m_el  = 0;
            if (hp != 32'd0) m_act = hp;
        end else begin
            m_stb = 1'b0;
            m_el++;
            if (m_el == longint'({32'd0, m_act}) * TD) begin
                m_el = 0;
                if (hp == 32'd0) begin
                    m_act = 32'd0;
                    m_led = 1'b0;
                end else begin
                    m_led = !m_led;
                    m_stb = 1'b1;
                    m_act = hp;
                end
            end
        end
    endtask

    // One clock edge, model update, then compare away from the edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        ncyc++;
        chk("led", {63'd0, led_a}, {63'd0, m_led});
        chk("stb", {63'd0, stb_a}, {63'd0, m_stb});
        chk("act", {32'd0, act_a}, {32'd0, m_act});
        chk("led_inv", {63'd0, led_b}, {63'd0, !m_led});
        chk("stb_inv", {63'd0, stb_b}, {63'd0, m_stb});
        chk("act_inv", {32'd0, act_b}, {32'd0, m_act});
    endtask

    task automatic do_reset();
        srst_n = 1'b0;
        hp     = 32'd0;
        cycle();
        cycle();
        srst_n = 1'b1;
    endtask

    // Edges until the next strobe; -1 if the bound expires.
    task automatic wait_stb(input int max, output int n);
        n = 0;
        while (1) begin
            cycle();
            n++;
            if (stb_a) break;
            if (n >= max) begin
                n = -1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [31:0] hp;
        int          cycles;
        int          exp_toggles;
        logic [31:0] exp_act;
        logic        exp_led;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int strobes;

        vecs[0] = '{hp: 32'd3,          cycles: 91,   exp_toggles: 3,  exp_act: 32'd3,          exp_led: 1'b1};
        vecs[1] = '{hp: 32'd3,          cycles: 90,   exp_toggles: 2,  exp_act: 32'd3,          exp_led: 1'b0};
        vecs[2] = '{hp: 32'd1,          cycles: 101,  exp_toggles: 10, exp_act: 32'd1,          exp_led: 1'b0};
        vecs[3] = '{hp: 32'd4,          cycles: 121,  exp_toggles: 3,  exp_act: 32'd4,          exp_led: 1'b1};
        vecs[4] = '{hp: 32'd0,          cycles: 50,   exp_toggles: 0,  exp_act: 32'd0,          exp_led: 1'b0};
        vecs[5] = '{hp: 32'hFFFF_FFFF,  cycles: 1000, exp_toggles: 0,  exp_act: 32'hFFFF_FFFF,  exp_led: 1'b0};

        srst_n = 1'b0;
        hp     = 32'd0;

        // Table-driven: steady half-periods from reset.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            chk("rst_led", {63'd0, led_a}, 64'd0);
            chk("rst_led_inv", {63'd0, led_b}, 64'd1);
            chk("rst_act", {32'd0, act_a}, 64'd0);
            hp      = vecs[v].hp;
            strobes = 0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                cycle();
                if (stb_a) strobes++;
            end
            chk("vec_toggles", 64'(strobes), 64'(vecs[v].exp_toggles));
            chk("vec_act", {32'd0, act_a}, {32'd0, vecs[v].exp_act});
            chk("vec_led", {63'd0, led_a}, {63'd0, vecs[v].exp_led});
        end

        // Half-period change mid-run lands only at the boundary.
        do_reset();
        hp = 32'd3;
        wait_stb(100, n);
        chk("chg_first", 64'(n), 64'd31);
        repeat (10) cycle();
        hp = 32'd5;
        wait_stb(100, n);
        chk("chg_finish_old", 64'(n), 64'd20);
        chk("chg_act", {32'd0, act_a}, 64'd5);
        wait_stb(100, n);
        chk("chg_new_period", 64'(n), 64'd50);

        // Zero at boundary: LED off, IDLE, no strobe; then re-entry.
        do_reset();
        hp = 32'd2;
        wait_stb(100, n);
        chk("zero_first", 64'(n), 64'd21);
        hp      = 32'd0;
        strobes = 0;
        repeat (20) begin
            cycle();
            if (stb_a) strobes++;
        end
        chk("zero_no_stb", 64'(strobes), 64'd0);
        chk("zero_act", {32'd0, act_a}, 64'd0);
        chk("zero_led", {63'd0, led_a}, 64'd0);
        repeat (5) cycle();
        hp = 32'd4;
        wait_stb(100, n);
        chk("reentry", 64'(n), 64'd41);

        // Reset mid-period aborts and restarts with a full half-period.
        do_reset();
        hp = 32'd4;
        wait_stb(100, n);
        chk("midrst_first", 64'(n), 64'd41);
        repeat (15) cycle();
        srst_n = 1'b0;
        repeat (3) begin
            cycle();
            chk("midrst_act", {32'd0, act_a}, 64'd0);
            chk("midrst_led_inv", {63'd0, led_b}, 64'd1);
        end
        srst_n = 1'b1;
        wait_stb(100, n);
        chk("midrst_after", 64'(n), 64'd41);

        // Randomized segments checked cycle by cycle against the model.
        for (int s = 0; s < 30; s++) begin
            int r;
            r      = $urandom_range(0, 9);
            srst_n = (r == 0) ? 1'b0 : 1'b1;
            r      = $urandom_range(0, 5);
            hp     = (r == 5) ? 32'($urandom_range(1, 8)) : 32'(r);
            repeat ($urandom_range(1, 120)) cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
